// File: rtl/case_1_prod_accum.sv
// case_1_prod_accum: sums FRAME_LEN signed products into a registered frame sum with sticky overflow; out_valid rises 1 cycle after the last beat.
// in_ready drops only while the final beat would overwrite an undrained sum; define CASE_1_PROD_ACCUM_SAT_EN to saturate instead of wrap.
module case_1_prod_accum #(
  parameter int PROD_W    = 14,
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_ovf,
  output logic                     out_valid,
  input  logic                     out_ready
);
  typedef enum logic {ACCUM, STALL} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W:0]   add_wide;
  logic [ACC_W-1:0] add_res;
  logic             add_ovf;
  logic             in_xfer, out_xfer, frame_done;

  // STALL marks "final beat is next and the previous sum is still held"; out_ready alone releases it.
  assign in_ready   = !(state_q == STALL && !out_ready);
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid_q && out_ready;
  assign frame_done = in_xfer && (cnt_q == LAST);

  always_comb begin
    add_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    add_ovf  = add_wide[ACC_W] ^ add_wide[ACC_W-1];
    add_res  = add_wide[ACC_W-1:0];
`ifdef CASE_1_PROD_ACCUM_SAT_EN
    if (add_ovf)
      add_res = add_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q && !out_xfer;
    if (frame_done) begin
      acc_d       = '0;
      ovf_d       = 1'b0;
      cnt_d       = '0;
      sum_d       = add_res;
      out_ovf_d   = ovf_q | add_ovf;
      out_valid_d = 1'b1;
    end else if (in_xfer) begin
      acc_d = add_res;
      ovf_d = ovf_q | add_ovf;
      cnt_d = cnt_q + 1'b1;
    end
    state_d = (cnt_d == LAST && out_valid_d) ? STALL : ACCUM;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_case_1_prod_accum.sv
// Bench for case_1_prod_accum: instance A (ACC_W=24, FRAME_LEN=4) and B (ACC_W=14, FRAME_LEN=2) share clock and reset.
module tb_case_1_prod_accum;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0]        vld, ordy;
  wire  [1:0]        rdy, ovld, ovf_o;
  logic signed [13:0] prod_a, prod_b;
  wire  signed [23:0] sum_a;
  wire  signed [13:0] sum_b;

  case_1_prod_accum #(.PROD_W(14), .ACC_W(24), .FRAME_LEN(4), .CNT_W(16)) u_dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_prod(prod_a), .in_valid(vld[0]), .in_ready(rdy[0]),
    .out_sum(sum_a), .out_ovf(ovf_o[0]), .out_valid(ovld[0]), .out_ready(ordy[0]));

  case_1_prod_accum #(.PROD_W(14), .ACC_W(14), .FRAME_LEN(2), .CNT_W(4)) u_dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_prod(prod_b), .in_valid(vld[1]), .in_ready(rdy[1]),
    .out_sum(sum_b), .out_ovf(ovf_o[1]), .out_valid(ovld[1]), .out_ready(ordy[1]));

  typedef struct { longint s; bit o; } exp_t;

  int     n_vec = 0, n_miss = 0;
  int     src0[$], src1[$];
  exp_t   q0[$], q1[$];
  int     vpct[2], rpct[2];
  longint m_acc[2];
  bit     m_ovf[2];
  int     m_cnt[2];
  bit     took[2], pend[2], hold[2], prev_v[2];
  longint held[2], last_sum[2];
  bit     last_ovf[2];
  int     nout[2], nvcyc[2], lat[2], tfirst[2];
  int     cyc = 0;

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic string tg(input string n, input int d);
    return $sformatf("%s_%s", (d == 0) ? "A" : "B", n);
  endfunction

  function automatic longint obs(input int d);
    return (d == 0) ? longint'(sum_a) : longint'(sum_b);
  endfunction

  // Reference add on plain integers: range check decides overflow, then clamp or wrap.
  function automatic longint madd(input longint acc, input longint p, input int w, output bit o);
    longint s, mx, mn, span;
    span = longint'(1) << w;
    mx   = span / 2 - 1;
    mn   = -(span / 2);
    s    = acc + p;
    o    = (s > mx) || (s < mn);
`ifdef CASE_1_PROD_ACCUM_SAT_EN
    if (s > mx) s = mx;
    else if (s < mn) s = mn;
`else
    if (s > mx) s = s - span;
    else if (s < mn) s = s + span;
`endif
    return s;
  endfunction

  // Monitor/scoreboard: evaluates the handshakes that the next rising edge will complete.
  always @(negedge clk) begin : engine
    longint s;
    bit     oa;
    exp_t   e;
    int     qn;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_acc[d] = 0; m_ovf[d] = 0; m_cnt[d] = 0;
        took[d] = 0; pend[d] = 0; hold[d] = 0; prev_v[d] = 0;
        if (d == 0) q0.delete(); else q1.delete();
      end else begin
        s = obs(d);
        if (pend[d]) chk_eq(tg("latency_vld", d), longint'(ovld[d]), 1);
        pend[d] = 0;
        if (hold[d]) begin
          chk_eq(tg("hold_sum", d), s, held[d]);
          chk_eq(tg("hold_vld", d), longint'(ovld[d]), 1);
        end
        if (ovld[d] && !prev_v[d]) lat[d] = cyc - tfirst[d];
        if (ovld[d]) nvcyc[d]++;
        prev_v[d] = ovld[d];
        took[d] = vld[d] && rdy[d];
        if (took[d]) begin
          if (m_cnt[d] == 0) tfirst[d] = cyc;
          m_acc[d] = madd(m_acc[d], (d == 0) ? longint'(prod_a) : longint'(prod_b),
                          (d == 0) ? 24 : 14, oa);
          m_ovf[d] = m_ovf[d] | oa;
          m_cnt[d]++;
          if (m_cnt[d] == ((d == 0) ? 4 : 2)) begin
            e.s = m_acc[d];
            e.o = m_ovf[d];
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            m_acc[d] = 0; m_ovf[d] = 0; m_cnt[d] = 0;
            pend[d] = 1;
          end
        end
        if (ovld[d] && ordy[d]) begin
          qn = (d == 0) ? q0.size() : q1.size();
          chk_eq(tg("exp_avail", d), longint'(qn > 0), 1);
          if (qn > 0) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk_eq(tg("sum", d), s, e.s);
            chk_eq(tg("ovf", d), longint'(ovf_o[d]), longint'(e.o));
          end
          nout[d]++;
          last_sum[d] = s;
          last_ovf[d] = ovf_o[d];
        end
        hold[d] = ovld[d] && !ordy[d];
        held[d] = s;
      end
    end
  end

  // Driver: presents the head of each source queue, with random valid/ready gaps.
  always @(posedge clk) begin
    #1;
    if (took[0] && src0.size() > 0) void'(src0.pop_front());
    if (took[1] && src1.size() > 0) void'(src1.pop_front());
    vld[0]  = (src0.size() > 0) && ($urandom_range(99) < vpct[0]);
    vld[1]  = (src1.size() > 0) && ($urandom_range(99) < vpct[1]);
    prod_a  = (src0.size() > 0) ? 14'(src0[0]) : 14'($urandom);
    prod_b  = (src1.size() > 0) ? 14'(src1[0]) : 14'($urandom);
    ordy[0] = $urandom_range(99) < rpct[0];
    ordy[1] = $urandom_range(99) < rpct[1];
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
             vld == 2'b00)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        chk_eq("idle_timeout", n, budget);
        return;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  int n0, n1, v0;

  initial begin
    rst_n = 1'b0;
    vld = 2'b00; ordy = 2'b00; prod_a = '0; prod_b = '0;
    vpct = '{100, 100};
    rpct = '{100, 100};
    nout = '{0, 0}; nvcyc = '{0, 0}; lat = '{0, 0}; tfirst = '{0, 0};
    took = '{0, 0};
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_eq(tg("rst_in_ready", d), longint'(rdy[d]), 1);
      chk_eq(tg("rst_out_valid", d), longint'(ovld[d]), 0);
      chk_eq(tg("rst_out_sum", d), obs(d), 0);
      chk_eq(tg("rst_out_ovf", d), longint'(ovf_o[d]), 0);
    end

    // Back-to-back frame on A: 100 - 3 + 8191 - 8192.
    n0 = nout[0]; v0 = nvcyc[0];
    src0 = '{100, -3, 8191, -8192};
    wait_idle(50);
    chk_eq("t1_outputs", nout[0] - n0, 1);
    chk_eq("t1_sum", last_sum[0], 96);
    chk_eq("t1_ovf", longint'(last_ovf[0]), 0);
    chk_eq("t1_latency", lat[0], 4);
    chk_eq("t1_valid_cycles", nvcyc[0] - v0, 1);

    // Stall on A: first sum never drained, second frame must stop at its last beat.
    rpct[0] = 0;
    n0 = nout[0];
    for (int i = 0; i < 8; i++) src0.push_back(1);
    repeat (14) @(negedge clk);
    chk_eq("t2_in_ready_stalled", longint'(rdy[0]), 0);
    chk_eq("t2_out_valid_held", longint'(ovld[0]), 1);
    chk_eq("t2_beats_left", src0.size(), 1);
    chk_eq("t2_no_out_yet", nout[0] - n0, 0);
    rpct[0] = 100;
    @(negedge clk);
    chk_eq("t2_in_ready_release", longint'(rdy[0]), 1);
    wait_idle(50);
    chk_eq("t2_outputs", nout[0] - n0, 2);
    chk_eq("t2_last_sum", last_sum[0], 4);

    // Overflow on B, positive then negative.
    src1 = '{8191, 8191};
    wait_idle(50);
`ifdef CASE_1_PROD_ACCUM_SAT_EN
    chk_eq("t3_sum", last_sum[1], 8191);
`else
    chk_eq("t3_sum", last_sum[1], -2);
`endif
    chk_eq("t3_ovf", longint'(last_ovf[1]), 1);
    src1 = '{-8192, -1};
    wait_idle(50);
`ifdef CASE_1_PROD_ACCUM_SAT_EN
    chk_eq("t4_sum", last_sum[1], -8192);
`else
    chk_eq("t4_sum", last_sum[1], 8191);
`endif
    chk_eq("t4_ovf", longint'(last_ovf[1]), 1);

    // Reset mid-frame on A: partial frame discarded.
    n0 = nout[0];
    src0 = '{7, 7};
    for (int i = 0; i < 20 && src0.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    chk_eq("t5_no_out_before_rst", nout[0] - n0, 0);
    chk_eq("t5_valid_before_rst", longint'(ovld[0]), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    src0.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    src0 = '{5, 5, 5, 5};
    wait_idle(50);
    chk_eq("t5_outputs", nout[0] - n0, 1);
    chk_eq("t5_sum", last_sum[0], 20);
    chk_eq("t5_ovf", longint'(last_ovf[0]), 0);

    // Random traffic: 1000 frames on each instance.
    n0 = nout[0]; n1 = nout[1];
    vpct = '{70, 70};
    rpct = '{60, 60};
    for (int i = 0; i < 4000; i++) src0.push_back(int'($urandom_range(16383)) - 8192);
    for (int i = 0; i < 2000; i++) src1.push_back(int'($urandom_range(16383)) - 8192);
    wait_idle(40000);
    chk_eq("rand_frames_A", nout[0] - n0, 1000);
    chk_eq("rand_frames_B", nout[1] - n1, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
